// File: rtl/regfile_alu_seq.sv
// Four-state command sequencer that reads two operands from an external
// register file, runs one ALU op, writes the result back and reports flags.
module regfile_alu_seq #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [DW-1:0] cmd_imm,
  output logic          rf_en,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [AW-1:0] rf_raddr1,
  output logic [AW-1:0] rf_raddr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zero,
  output logic          rsp_carry
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] imm_q;
  logic [AW-1:0] raddr1_q, raddr2_q;
  logic [DW-1:0] opa_q, opb_q;
  logic [DW-1:0] result_q, result_d;
  logic          zero_q, carry_q, carry_d;
  logic          accept;
  logic [DW:0]   sum, diff;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rf_en     = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid) state_d = S_READ;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB: begin
        rsp_valid = 1'b1;
        rf_en     = (op_q != OP_CMP);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Carry and borrow come from the extra top bit of a DW+1 wide add/subtract.
  always_comb begin
    sum      = {1'b0, opa_q} + {1'b0, opb_q};
    diff     = {1'b0, opa_q} - {1'b0, opb_q};
    result_d = '0;
    carry_d  = 1'b0;
    case (op_q)
      OP_ADD: begin
        result_d = sum[DW-1:0];
        carry_d  = sum[DW];
      end
      OP_SUB, OP_CMP: begin
        result_d = diff[DW-1:0];
        carry_d  = diff[DW];
      end
      OP_AND:  result_d = opa_q & opb_q;
      OP_OR:   result_d = opa_q | opb_q;
      OP_XOR:  result_d = opa_q ^ opb_q;
      OP_MOV:  result_d = opa_q;
      OP_LDI:  result_d = imm_q;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= cmd_op;
        rd_q     <= cmd_rd;
        imm_q    <= cmd_imm;
        raddr1_q <= cmd_rs1;
        raddr2_q <= cmd_rs2;
      end
      if (state_q == S_READ) begin
        opa_q <= rf_rdata1;
        opb_q <= rf_rdata2;
      end
      // Response registers only move at the end of EXEC, so they hold between commands.
      if (state_q == S_EXEC) begin
        result_q <= result_d;
        zero_q   <= (result_d == '0);
        carry_q  <= carry_d;
      end
    end
  end

  assign rf_raddr1 = raddr1_q;
  assign rf_raddr2 = raddr2_q;
  assign rf_waddr  = rd_q;
  assign rf_wdata  = result_q;
  assign rsp_data  = result_q;
  assign rsp_zero  = zero_q;
  assign rsp_carry = carry_q;

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Bench for regfile_alu_seq: a behavioural register file plus a scoreboard
// of expected responses computed from an architectural register model.
module tb_regfile_alu_seq;

  localparam int DW = 8;
  localparam int AW = 3;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] AND = 3'd2;
  localparam logic [2:0] OR  = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] MOV = 3'd5;
  localparam logic [2:0] LDI = 3'd6;
  localparam logic [2:0] CMP = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [AW-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic          rf_en;
  logic [AW-1:0] rf_waddr, rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_wdata, rf_rdata1, rf_rdata2;
  logic          rsp_valid, rsp_zero, rsp_carry;
  logic [DW-1:0] rsp_data;

  typedef struct {
    logic [DW-1:0] data;
    logic          zero;
    logic          carry;
    logic          write;
    logic [AW-1:0] rd;
    int            acceptCycle;
  } expect_t;

  expect_t       scoreQ[$];
  logic [DW-1:0] rfMem[8];
  int            modelRegs[8];
  int            checkCount = 0;
  int            errorCount = 0;
  int            cycleCount = 0;
  int            rfEnCount = 0;
  int            rspCount = 0;
  int            lastAccept = 0;
  int            lastReadyLow = 0;

  regfile_alu_seq #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rf_en(rf_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry)
  );

  always #5 clk = ~clk;

  // External register file: combinational read, write on the rising edge, not reset.
  initial for (int i = 0; i < 8; i++) rfMem[i] = '0;
  always @(posedge clk) if (rf_en) rfMem[rf_waddr] <= rf_wdata;
  assign rf_rdata1 = rfMem[rf_raddr1];
  assign rf_rdata2 = rfMem[rf_raddr2];

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: every response is compared with the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_en) rfEnCount++;
      if (rsp_valid) begin
        rspCount++;
        if (scoreQ.size() == 0) begin
          checkOutput("rspUnexpected", 32'(rsp_valid), 32'd0);
        end else begin
          expect_t e;
          e = scoreQ.pop_front();
          checkOutput("rspData", 32'(rsp_data), 32'(e.data));
          checkOutput("rspZero", 32'(rsp_zero), 32'(e.zero));
          checkOutput("rspCarry", 32'(rsp_carry), 32'(e.carry));
          checkOutput("rfEn", 32'(rf_en), 32'(e.write));
          if (e.write) begin
            checkOutput("rfWaddr", 32'(rf_waddr), 32'(e.rd));
            checkOutput("rfWdata", 32'(rf_wdata), 32'(e.data));
          end
          checkOutput("latency", 32'(cycleCount - e.acceptCycle), 32'd2);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge inside READ with cmd_valid still high.
  task automatic applyStimulus(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                               input int imm, input bit expectRsp);
    int      waited;
    int      a, b, r;
    expect_t e;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = AW'(rd);
    cmd_rs1   = AW'(rs1);
    cmd_rs2   = AW'(rs2);
    cmd_imm   = DW'(imm);
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("acceptTimeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    lastReadyLow = waited;
    @(posedge clk);
    #1;
    lastAccept = cycleCount;
    a = modelRegs[rs1];
    b = modelRegs[rs2];
    e.carry = 1'b0;
    case (op)
      ADD: begin r = a + b; e.carry = (r > 255); r = r % 256; end
      SUB, CMP: begin e.carry = (a < b); r = (a - b + 256) % 256; end
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      MOV: r = a;
      default: r = imm % 256;
    endcase
    e.data        = DW'(r);
    e.zero        = (r == 0);
    e.write       = (op != CMP);
    e.rd          = AW'(rd);
    e.acceptCycle = lastAccept;
    if (expectRsp) begin
      scoreQ.push_back(e);
      if (e.write) modelRegs[rd] = r;
    end
    @(negedge clk);
    checkOutput("readAddr1", 32'(rf_raddr1), 32'(rs1));
    checkOutput("readAddr2", 32'(rf_raddr2), 32'(rs2));
  endtask

  task automatic drainQueue();
    int waited;
    waited    = 0;
    cmd_valid = 1'b0;
    while (scoreQ.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (scoreQ.size() != 0) begin
      checkOutput("drainTimeout", 32'(scoreQ.size()), 32'd0);
      scoreQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic runCmd(input logic [2:0] op, input int rd, input int rs1, input int rs2, input int imm);
    applyStimulus(op, rd, rs1, rs2, imm, 1'b1);
    drainQueue();
  endtask

  initial begin
    int prevAccept, enBefore, rspBefore;
    for (int i = 0; i < 8; i++) modelRegs[i] = 0;

    repeat (2) @(negedge clk);
    checkOutput("resetReady", 32'(cmd_ready), 32'd1);
    checkOutput("resetRfEn", 32'(rf_en), 32'd0);
    checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("resetOutputs", {rsp_data, 5'(rsp_zero), 3'(rsp_carry), 5'(rf_waddr), 3'(rf_raddr1)}, 32'd0);
    checkOutput("resetData", {8'(rf_raddr2), rf_wdata, 16'd0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] LDI");
    runCmd(LDI, 3, 0, 0, 'hAA);
    runCmd(LDI, 5, 0, 0, 'h55);
    checkOutput("rfR3", 32'(rfMem[3]), 32'hAA);
    checkOutput("rfR5", 32'(rfMem[5]), 32'h55);

    $display("[TB] ALU ops");
    runCmd(ADD, 7, 3, 5, 0);
    runCmd(ADD, 7, 7, 7, 0);
    runCmd(SUB, 1, 5, 3, 0);
    runCmd(XOR, 2, 3, 3, 0);
    checkOutput("rfR7", 32'(rfMem[7]), 32'hFE);
    checkOutput("rfR1", 32'(rfMem[1]), 32'hAB);

    $display("[TB] CMP");
    enBefore = rfEnCount;
    runCmd(CMP, 0, 3, 3, 0);
    checkOutput("cmpNoWrite", 32'(rfEnCount - enBefore), 32'd0);
    checkOutput("cmpR3Kept", 32'(rfMem[3]), 32'hAA);

    $display("[TB] back-to-back");
    applyStimulus(LDI, 7, 0, 0, 'h3C, 1'b1);
    prevAccept = lastAccept;
    applyStimulus(MOV, 4, 7, 0, 0, 1'b1);
    checkOutput("b2bSpacing", 32'(lastAccept - prevAccept), 32'd4);
    checkOutput("b2bReadyLow", 32'(lastReadyLow), 32'd3);
    prevAccept = lastAccept;
    applyStimulus(AND, 0, 4, 3, 0, 1'b1);
    checkOutput("b2bSpacing2", 32'(lastAccept - prevAccept), 32'd4);
    applyStimulus(OR, 6, 4, 5, 0, 1'b1);
    drainQueue();
    checkOutput("rfR4", 32'(rfMem[4]), 32'h3C);

    $display("[TB] reset mid-command");
    runCmd(LDI, 6, 0, 0, 'h34);
    enBefore  = rfEnCount;
    rspBefore = rspCount;
    applyStimulus(LDI, 6, 0, 0, 'h12, 1'b0);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abortRfEn", 32'(rf_en), 32'd0);
    checkOutput("abortReady", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abortNoRsp", 32'(rspCount - rspBefore), 32'd0);
    checkOutput("abortNoWrite", 32'(rfEnCount - enBefore), 32'd0);
    runCmd(MOV, 0, 6, 6, 0);
    checkOutput("abortR6Kept", 32'(rfMem[6]), 32'h34);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
